// File: rtl/fetch_stage.sv
// Instruction-fetch stage feeding the IF/ID register. It owns the PC and issues
// level-held instruction-memory reads. A one-entry hold buffer absorbs a stall
// downstream, and the stage also handles redirects and halt.
// Ports:
//   CLK, nRST           clock, synchronous active-low reset
//   imemREN, imemaddr   read request / address to instruction memory
//   ihit, imemload      memory response
//   stall               IF/ID cannot accept this cycle
//   redirect, redirect_pc  taken branch/jump and its target
//   halt                stop fetching
//   instruction_out, next_address_out, fetch_valid, flush_ifid  to IF/ID
//   pc_out, halted      current PC, fetch stopped
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_INC   = 4
) (
  input  logic        CLK,
  input  logic        nRST,
  output logic        imemREN,
  output logic [31:0] imemaddr,
  input  logic        ihit,
  input  logic [31:0] imemload,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic [31:0] instruction_out,
  output logic [31:0] next_address_out,
  output logic        fetch_valid,
  output logic        flush_ifid,
  output logic [31:0] pc_out,
  output logic        halted
);

  localparam logic [1:0] FETCH  = 2'd0;
  localparam logic [1:0] HOLD   = 2'd1;
  localparam logic [1:0] SQUASH = 2'd2;
  localparam logic [1:0] HALTED = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] hold_instr_q, hold_instr_d;
  logic [31:0] hold_next_q, hold_next_d;
  logic [31:0] saved_target_q, saved_target_d;
  logic [31:0] pc_inc;

  assign pc_inc   = pc_q + 32'(PC_INC);
  assign pc_out   = pc_q;
  assign imemaddr = pc_q;

  // State register
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q        <= FETCH;
      pc_q           <= RESET_PC;
      hold_instr_q   <= '0;
      hold_next_q    <= '0;
      saved_target_q <= '0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      hold_instr_q   <= hold_instr_d;
      hold_next_q    <= hold_next_d;
      saved_target_q <= saved_target_d;
    end
  end

  // Next-state and IF/ID outputs; priority redirect > halt > ihit/stall
  always_comb begin
    state_d          = state_q;
    pc_d             = pc_q;
    hold_instr_d     = hold_instr_q;
    hold_next_d      = hold_next_q;
    saved_target_d   = saved_target_q;
    imemREN          = 1'b0;
    fetch_valid      = 1'b0;
    flush_ifid       = 1'b0;
    halted           = 1'b0;
    instruction_out  = imemload;
    next_address_out = pc_inc;

    case (state_q)
      FETCH: begin
        imemREN = 1'b1;
        if (redirect) begin
          flush_ifid = 1'b1;
          if (ihit) begin
            pc_d = redirect_pc;
          end else begin
            // Keep the outstanding address stable; retarget once it returns
            saved_target_d = redirect_pc;
            state_d        = SQUASH;
          end
        end else if (halt) begin
          state_d = HALTED;
        end else if (ihit) begin
          pc_d = pc_inc;
          if (stall) begin
            hold_instr_d = imemload;
            hold_next_d  = pc_inc;
            state_d      = HOLD;
          end else begin
            fetch_valid = 1'b1;
          end
        end
      end
      HOLD: begin
        instruction_out  = hold_instr_q;
        next_address_out = hold_next_q;
        if (redirect) begin
          flush_ifid = 1'b1;
          pc_d       = redirect_pc;
          state_d    = FETCH;
        end else if (halt) begin
          state_d = HALTED;
        end else if (!stall) begin
          fetch_valid = 1'b1;
          state_d     = FETCH;
        end
      end
      SQUASH: begin
        imemREN = 1'b1;
        // Halt is ignored here: the halting instruction is on the wrong path
        if (redirect) begin
          flush_ifid     = 1'b1;
          saved_target_d = redirect_pc;
        end
        if (ihit) begin
          pc_d    = redirect ? redirect_pc : saved_target_q;
          state_d = FETCH;
        end
      end
      default: begin
        halted = 1'b1;
      end
    endcase

    if (!nRST) begin
      imemREN     = 1'b0;
      fetch_valid = 1'b0;
      flush_ifid  = 1'b0;
      halted      = 1'b0;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with hand-computed expectations.
module tb_fetch_stage;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        halt;
  logic [31:0] instruction_out;
  logic [31:0] next_address_out;
  logic        fetch_valid;
  logic        flush_ifid;
  logic [31:0] pc_out;
  logic        halted;

  int n_checks = 0;
  int n_fail   = 0;

  fetch_stage #(.RESET_PC(32'h0000_0000), .PC_INC(4)) dut (
    .CLK(CLK), .nRST(nRST),
    .imemREN(imemREN), .imemaddr(imemaddr),
    .ihit(ihit), .imemload(imemload),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt),
    .instruction_out(instruction_out), .next_address_out(next_address_out),
    .fetch_valid(fetch_valid), .flush_ifid(flush_ifid),
    .pc_out(pc_out), .halted(halted)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are then changed 1ns after the edge
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic r, input logic h, input logic s, input logic hl,
                       input logic [31:0] rpc, input logic [31:0] load);
    redirect = r; ihit = h; stall = s; halt = hl; redirect_pc = rpc; imemload = load;
    #1;
  endtask

  initial begin
    nRST = 1'b0;
    drive(0, 0, 0, 0, 32'h0, 32'h0);
    step();
    check_eq("rst_pc", pc_out, 32'h0);
    check_eq("rst_ren", 32'(imemREN), 32'h0);
    check_eq("rst_valid", 32'(fetch_valid), 32'h0);
    check_eq("rst_halted", 32'(halted), 32'h0);
    nRST = 1'b1;

    // Streaming fetch, ihit every cycle
    for (int k = 0; k < 2; k++) begin
      drive(0, 1, 0, 0, 32'h0, 32'h1000 + 32'(k));
      check_eq("seq_addr", imemaddr, 32'(4 * k));
      check_eq("seq_next", next_address_out, 32'(4 * k + 4));
      check_eq("seq_valid", 32'(fetch_valid), 32'h1);
      step();
    end

    // Stall at pc=8: capture into hold buffer
    drive(0, 1, 1, 0, 32'h0, 32'h2001_0005);
    check_eq("stall_addr", imemaddr, 32'h8);
    check_eq("stall_valid", 32'(fetch_valid), 32'h0);
    step();
    for (int k = 0; k < 2; k++) begin
      drive(0, 0, 1, 0, 32'h0, 32'hDEAD_BEEF);
      check_eq("hold_ren", 32'(imemREN), 32'h0);
      check_eq("hold_valid", 32'(fetch_valid), 32'h0);
      step();
    end
    drive(0, 0, 0, 0, 32'h0, 32'hDEAD_BEEF);
    check_eq("rel_valid", 32'(fetch_valid), 32'h1);
    check_eq("rel_instr", instruction_out, 32'h2001_0005);
    check_eq("rel_next", next_address_out, 32'd12);
    step();
    drive(0, 0, 0, 0, 32'h0, 32'h0);
    check_eq("after_hold_addr", imemaddr, 32'd12);
    check_eq("after_hold_valid", 32'(fetch_valid), 32'h0);
    drive(0, 1, 0, 0, 32'h0, 32'h1234_5678);
    check_eq("addr12_valid", 32'(fetch_valid), 32'h1);
    check_eq("addr12_next", next_address_out, 32'd16);
    step();

    // Redirect with request outstanding at pc=16
    drive(1, 0, 0, 0, 32'h40, 32'h0);
    check_eq("sq_flush", 32'(flush_ifid), 32'h1);
    check_eq("sq_valid", 32'(fetch_valid), 32'h0);
    step();
    drive(0, 0, 0, 0, 32'h0, 32'h0);
    check_eq("sq_addr_held", imemaddr, 32'd16);
    check_eq("sq_ren", 32'(imemREN), 32'h1);
    check_eq("sq_noflush", 32'(flush_ifid), 32'h0);
    step();
    drive(0, 1, 0, 0, 32'h0, 32'hBAD0_0010);
    check_eq("sq_drop_valid", 32'(fetch_valid), 32'h0);
    check_eq("sq_drop_addr", imemaddr, 32'd16);
    step();
    drive(0, 0, 0, 0, 32'h0, 32'h0);
    check_eq("sq_target", imemaddr, 32'h40);

    // Latest redirect wins while squashing
    drive(1, 0, 0, 0, 32'h80, 32'h0);
    step();
    drive(1, 0, 0, 0, 32'hC0, 32'h0);
    check_eq("sq2_flush", 32'(flush_ifid), 32'h1);
    check_eq("sq2_addr", imemaddr, 32'h40);
    step();
    drive(0, 1, 0, 0, 32'h0, 32'h0);
    check_eq("sq2_valid", 32'(fetch_valid), 32'h0);
    step();
    drive(0, 0, 0, 0, 32'h0, 32'h0);
    check_eq("sq2_target", imemaddr, 32'hC0);

    // Redirect and halt together in HOLD: redirect wins
    drive(0, 1, 1, 0, 32'h0, 32'h5555_5555);
    step();
    drive(1, 0, 1, 1, 32'h100, 32'h0);
    check_eq("hr_flush", 32'(flush_ifid), 32'h1);
    check_eq("hr_valid", 32'(fetch_valid), 32'h0);
    step();
    drive(0, 0, 0, 0, 32'h0, 32'h0);
    check_eq("hr_addr", imemaddr, 32'h100);
    check_eq("hr_halted", 32'(halted), 32'h0);
    check_eq("hr_ren", 32'(imemREN), 32'h1);
    drive(0, 1, 0, 1, 32'h0, 32'h0);
    check_eq("halt_valid", 32'(fetch_valid), 32'h0);
    step();
    drive(1, 1, 0, 0, 32'h300, 32'h0);
    check_eq("halted_flag", 32'(halted), 32'h1);
    check_eq("halted_ren", 32'(imemREN), 32'h0);
    check_eq("halted_flush", 32'(flush_ifid), 32'h0);
    check_eq("halted_valid", 32'(fetch_valid), 32'h0);
    step();
    drive(0, 0, 0, 0, 32'h0, 32'h0);
    check_eq("halted_pc", pc_out, 32'h100);
    check_eq("halted_stays", 32'(halted), 32'h1);

    // PC wrap: reset, then redirect to the top word
    nRST = 1'b0;
    step();
    nRST = 1'b1;
    drive(1, 1, 0, 0, 32'hFFFF_FFFC, 32'h0);
    step();
    drive(0, 1, 0, 0, 32'h0, 32'h7777_0000);
    check_eq("wrap_addr", imemaddr, 32'hFFFF_FFFC);
    check_eq("wrap_next", next_address_out, 32'h0);
    check_eq("wrap_valid", 32'(fetch_valid), 32'h1);
    step();
    drive(0, 0, 0, 0, 32'h0, 32'h0);
    check_eq("wrap_pc", pc_out, 32'h0);

    // Reset while squashing
    drive(1, 0, 0, 0, 32'h200, 32'h0);
    step();
    nRST = 1'b0;
    drive(0, 1, 0, 0, 32'h0, 32'h0);
    check_eq("rsq_valid", 32'(fetch_valid), 32'h0);
    check_eq("rsq_flush", 32'(flush_ifid), 32'h0);
    check_eq("rsq_ren", 32'(imemREN), 32'h0);
    step();
    nRST = 1'b1;
    drive(0, 0, 0, 0, 32'h0, 32'h0);
    check_eq("rsq_pc", pc_out, 32'h0);
    check_eq("rsq_ren_after", 32'(imemREN), 32'h1);
    drive(0, 1, 0, 0, 32'h0, 32'h0);
    check_eq("rsq_fetch_valid", 32'(fetch_valid), 32'h1);
    check_eq("rsq_next", next_address_out, 32'h4);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage pipeline, directly upstream of the IF/ID pipeline register.
- Owns the PC and issues level-held instruction-memory read requests.
- Absorbs a downstream stall with a one-entry hold buffer.
- Handles branch/jump redirects and halt, then presents instruction, PC+4, a write-enable pulse and a flush pulse to IF/ID.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
PC_INC, 4, byte increment per sequential fetch

Ports:
CLK  input  1  clock, all state updates on rising edge
nRST  input  1  synchronous active-low reset
imemREN  output  1  instruction read request, held until ihit
imemaddr  output  32  instruction address, equals pc_out
ihit  input  1  memory returns imemload this cycle
imemload  input  32  fetched instruction word
stall  input  1  IF/ID cannot accept this cycle (hazard unit)
redirect  input  1  taken branch/jump resolved downstream
redirect_pc  input  32  redirect target
halt  input  1  HALT decoded downstream; stop fetching
instruction_out  output  32  instruction to IF/ID instruction_in
next_address_out  output  32  PC+4 of that instruction, to IF/ID next_address_in
fetch_valid  output  1  IF/ID WEN: instruction_out/next_address_out valid this cycle
flush_ifid  output  1  IF/ID flush: insert NOP this cycle
pc_out  output  32  current PC
halted  output  1  fetch stopped

Behaviour:
- Reset: synchronous; on rising CLK with nRST=0: pc<=RESET_PC, state<=FETCH, hold_instr<=0, hold_next<=0, saved_target<=0.
- While nRST=0, imemREN, fetch_valid, flush_ifid and halted are forced to 0.
- Reset mid-operation (any state) aborts the operation; no pulse is emitted.
- Registers: pc, state, hold_instr, hold_next, saved_target. PC arithmetic is modulo 2^32 (32'hFFFF_FFFC+4 wraps to 0).
- fetch_valid, flush_ifid, instruction_out and next_address_out are combinational from state and inputs, so ihit reaches IF/ID in the same cycle (0-cycle latency).
- Priority in every state: redirect > halt > ihit/stall.
- States:
  FETCH: imemREN=1, imemaddr=pc, instruction_out=imemload, next_address_out=pc+PC_INC.
    - redirect: flush_ifid=1, fetch_valid=0. If ihit, the response is dropped, pc<=redirect_pc, state stays FETCH. If no ihit, saved_target<=redirect_pc, go SQUASH (address stays stable while the request is outstanding).
    - halt (no redirect): fetch_valid=0, go HALTED; any ihit response is dropped.
    - ihit & !stall: fetch_valid=1, pc<=pc+PC_INC, stay FETCH.
    - ihit & stall: fetch_valid=0, hold_instr<=imemload, hold_next<=pc+PC_INC, pc<=pc+PC_INC, go HOLD.
    - no ihit: hold all state.
  HOLD: imemREN=0, instruction_out=hold_instr, next_address_out=hold_next, fetch_valid=!stall.
    - redirect: flush_ifid=1, fetch_valid=0, buffer discarded, pc<=redirect_pc, go FETCH.
    - halt: fetch_valid=0, go HALTED.
    - !stall: go FETCH.
  SQUASH: imemREN=1, imemaddr=pc, fetch_valid=0.
    - New redirect: saved_target<=redirect_pc (latest wins), flush_ifid=1.
    - On ihit: response dropped, pc<=saved_target (or redirect_pc if redirect is asserted in the same cycle), go FETCH.
    - halt is ignored in SQUASH; the halting instruction is younger than the redirect.
  HALTED: imemREN=0, fetch_valid=0, flush_ifid=0, halted=1. Absorbing until reset; redirect and halt are ignored.
- Invariants:
  - fetch_valid and flush_ifid are never both 1.
  - At most one fetch_valid per fetched instruction.
  - imemaddr never changes while imemREN=1 and ihit=0.

Test Plan:
- Reset with RESET_PC=0, ihit tied 1, stall=0 -> fetch_valid each cycle; next_address_out 4,8,12; imemaddr 0,4,8.
- At pc=8, ihit=1 with stall=1 for 3 cycles, imemload=32'h2001_0005 -> HOLD; imemREN=0; fetch_valid=0 for 3 cycles; on stall release, exactly one fetch_valid with instruction 32'h2001_0005 and next 12; next fetch at addr 12.
- ihit=0 at pc=16, redirect=1 with target 32'h40 -> flush_ifid=1; addr held at 16 until ihit; that response dropped; next imemaddr=32'h40; no fetch_valid for addr 16.
- Redirect 0x80 in SQUASH, then redirect 0xC0 before ihit -> fetch resumes at 0xC0.
- In HOLD: redirect=1 and halt=1 simultaneously, target 0x100 -> flush_ifid=1, buffer dropped, state FETCH at 0x100, halted=0. Then halt=1 -> halted=1, imemREN=0 permanently.
- pc=32'hFFFF_FFFC, ihit=1 -> next_address_out=0, pc wraps to 0.
- nRST=0 for one edge during SQUASH -> pc=RESET_PC, state FETCH; no flush_ifid or fetch_valid emitted.
